program_loader: RTL and testbench
=================================

# program_loader

Byte-stream program loader that sits directly upstream of the 16-bit single-cycle CPU. It assembles a length-prefixed byte stream into 16-bit instruction words and buffers the whole program. It then bursts the words into the CPU's instruction memory by driving the CPU's instruction-load and PC-reset inputs. Finally it restarts the CPU at address 0.

## Interface
- DEPTH, 16: maximum program length in 16-bit words; buffer size.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset of all loader state.
- byte_in  in  8  incoming stream byte.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- instruction_in  out  16  word to CPU instruction memory.
- load_instruction  out  1  CPU instruction-memory write enable.
- cpu_pc_reset  out  1  drives CPU pc_reset; high holds the CPU PC at 0.
- busy  out  1  a load is in progress (any state other than IDLE, ERROR).
- done  out  1  one-cycle pulse after a successful load.
- load_error  out  1  sticky; the declared length was out of range.

## Operation
- Stream format, big-endian: count_hi, count_lo, then N words as hi byte followed by lo byte. N = {count_hi, count_lo}.
- A byte transfers on a rising edge where byte_valid && byte_ready.
- byte_ready = 1 in IDLE, CNT_LO, DATA_HI, DATA_LO, and 0 elsewhere.
- States and transitions:
  - IDLE: on transfer, latch count_hi and go to CNT_LO.
  - CNT_LO: on transfer, form N.
    - N = 0: go to IDLE. No burst, no done, loaded flag unchanged.
    - N > DEPTH: go to ERROR.
    - Otherwise: clear the word index and go to DATA_HI.
  - DATA_HI: on transfer, latch the hi byte and go to DATA_LO.
  - DATA_LO: on transfer, write {hi, lo} to buf[index] and increment index.
    - If index reaches N: go to BURST_RST.
    - Otherwise: go to DATA_HI.
  - BURST_RST: one cycle, clear the burst index, go to BURST.
  - BURST: N cycles. Each cycle: instruction_in = buf[k], load_instruction = 1, k increments. After k = N-1, go to RESTART.
  - RESTART: one cycle. Set the loaded flag, go to IDLE, and assert done in the following IDLE cycle.
  - ERROR: load_error = 1. Stays here until reset.
- cpu_pc_reset = 0 only in BURST, or in IDLE with loaded = 1. It is 1 in every other state.
  - The CPU is held in reset from power-up until the first successful load.
  - The CPU is held in reset as soon as count_hi of a reload has been accepted.
- Burst addressing: the CPU PC is 0 on the first BURST cycle and advances by 1 per clock, so word k is written at address k.
  - Instructions executed by the CPU during BURST may modify CPU registers or data memory. The loader does not restore that state; programs initialise their own registers.
- Buffer contents persist across loads; only the words 0..N-1 are rewritten.
- instruction_in = 0 whenever load_instruction = 0.

## Timing
- Reset values: byte_ready = 1, instruction_in = 0, load_instruction = 0, cpu_pc_reset = 1, busy = 0, done = 0, load_error = 0, loaded = 0. State is IDLE.
- All outputs are Moore functions of registered state, with no combinational path from byte_valid or byte_in.
- Latency is counted from the edge that accepts the final lo byte:
  - 1 cycle in BURST_RST.
  - N cycles of load_instruction.
  - 1 cycle in RESTART.
  - done high in cycle N+2; the CPU runs from PC 0 in that same cycle.
- byte_valid may drop for any number of cycles between bytes. The state is held and no timeout applies.
- Reset asserted mid-stream or mid-burst immediately returns to the reset values and clears loaded. A partially written program never runs; the CPU stays in reset until a full reload.
- byte_valid during BURST_RST, BURST, RESTART or ERROR is ignored (byte_ready = 0). The upstream source must hold the byte.

## Test plan
- Stream 00 03 A1 23 B4 56 C7 89, byte_valid continuous -> one cycle of cpu_pc_reset = 1, then 3 cycles of load_instruction with instruction_in A123, B456, C789. Then RESTART, done pulse, cpu_pc_reset = 0, CPU instruction memory holds those words at addresses 0..2.
- Same stream with byte_valid low for 5 cycles between every byte -> identical burst content and ordering. byte_ready = 0 only from BURST_RST to RESTART.
- Stream 00 00 -> returns to IDLE, no load_instruction, no done. cpu_pc_reset = 1 if no prior load, otherwise returns to 0 once back in IDLE.
- Stream 00 11 with DEPTH = 16 -> ERROR, load_error = 1, byte_ready = 0 and both held until reset. After reset, load_error = 0.
- Load a 2-word program, let the CPU run, then stream 00 01 0F FF -> cpu_pc_reset rises on the edge after count_hi is accepted. A 1-word burst of 0FFF follows, then done.
- Assert reset during the second BURST cycle of a 4-word load -> next cycle load_instruction = 0, cpu_pc_reset = 1, busy = 0, state IDLE. A following full load completes normally.

Source files
------------

// File: rtl/program_loader_if.sv
// ============================================================================
// Module   : program_loader_if
// Brief    : Byte-stream input and CPU instruction-load bundle for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic        load_instruction;
    logic        cpu_pc_reset;
    logic        busy;
    logic        done;
    logic        load_error;

    // master: byte source / CPU side; slave: the loader itself
    modport master (
        output byte_in, byte_valid,
        input  byte_ready, instruction_in, load_instruction,
        input  cpu_pc_reset, busy, done, load_error
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, instruction_in, load_instruction,
        output cpu_pc_reset, busy, done, load_error
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Brief    : Assembles a length-prefixed byte stream into 16-bit words, buffers
//            the program, bursts it into CPU instruction memory, then restarts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] C_DEPTH = 16'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CNT_LO    = 4'd1,
        S_DATA_HI   = 4'd2,
        S_DATA_LO   = 4'd3,
        S_BURST_RST = 4'd4,
        S_BURST     = 4'd5,
        S_RESTART   = 4'd6,
        S_ERROR     = 4'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_hi;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_idx;
    logic            r_loaded;
    logic            r_done;
    logic [15:0]     r_buf [DEPTH];

    logic            w_ready;
    logic            w_load;
    logic            w_pc_reset;
    logic            w_busy;
    logic            w_err;
    logic [15:0]     w_n;

    assign w_n = {r_hi, bus.byte_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Outputs depend on r_state only; byte_valid steers just the next state.
    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_load     = 1'b0;
        w_pc_reset = 1'b1;
        w_busy     = 1'b1;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready    = 1'b1;
                w_busy     = 1'b0;
                w_pc_reset = ~r_loaded;
                if (bus.byte_valid) w_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                w_ready = 1'b1;
                if (bus.byte_valid) begin
                    if (w_n == 16'd0)        w_next = S_IDLE;
                    else if (w_n > C_DEPTH)  w_next = S_ERROR;
                    else                     w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                w_ready = 1'b1;
                if (bus.byte_valid) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                w_ready = 1'b1;
                if (bus.byte_valid)
                    w_next = (r_idx + CW'(1) == r_count) ? S_BURST_RST : S_DATA_HI;
            end
            S_BURST_RST: w_next = S_BURST;
            S_BURST: begin
                w_load     = 1'b1;
                w_pc_reset = 1'b0;
                if (r_idx == r_count - CW'(1)) w_next = S_RESTART;
            end
            S_RESTART: w_next = S_IDLE;
            S_ERROR: begin
                w_busy = 1'b0;
                w_err  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= 8'd0;
            r_count  <= '0;
            r_idx    <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_RESTART);
            case (r_state)
                S_IDLE:      if (bus.byte_valid) r_hi <= bus.byte_in;
                S_CNT_LO: begin
                    if (bus.byte_valid) begin
                        r_count <= w_n[CW-1:0];
                        r_idx   <= '0;
                    end
                end
                S_DATA_HI:   if (bus.byte_valid) r_hi <= bus.byte_in;
                S_DATA_LO:   if (bus.byte_valid) r_idx <= r_idx + CW'(1);
                S_BURST_RST: r_idx <= '0;
                S_BURST:     r_idx <= r_idx + CW'(1);
                S_RESTART:   r_loaded <= 1'b1;
                default:     ;
            endcase
        end
    end

    // Program storage survives reset and reloads; only written words change.
    always_ff @(posedge clk) begin
        if (r_state == S_DATA_LO && bus.byte_valid)
            r_buf[r_idx[IW-1:0]] <= {r_hi, bus.byte_in};
    end

    assign bus.byte_ready       = w_ready;
    assign bus.load_instruction = w_load;
    assign bus.instruction_in   = w_load ? r_buf[r_idx[IW-1:0]] : 16'd0;
    assign bus.cpu_pc_reset     = w_pc_reset;
    assign bus.busy             = w_busy;
    assign bus.done             = r_done;
    assign bus.load_error       = w_err;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed self-checking bench with a burst scoreboard and CPU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic clk;
    logic reset;
    program_loader_if bus ();

    program_loader #(.DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q [$];
    logic [15:0] prog  [16];
    logic [15:0] imem  [256];
    logic [7:0]  pc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Simple CPU: PC held at 0 under pc_reset, else advances once per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 8'd0;
        else begin
            if (bus.load_instruction) imem[pc] <= bus.instruction_in;
            pc <= bus.cpu_pc_reset ? 8'd0 : pc + 8'd1;
        end
    end

    // Scoreboard: every burst beat must be the next word the bench streamed.
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.load_instruction) chk("idle_instr_zero", bus.instruction_in, 16'h0000);
            else if (exp_q.size() == 0) chk("unexpected_load", {15'd0, bus.load_instruction}, 16'h0000);
            else begin
                chk("burst_word", bus.instruction_in, exp_q.pop_front());
                chk("burst_pc_run", {15'd0, bus.cpu_pc_reset}, 16'h0000);
            end
            if (bus.load_error) chk("err_not_ready", {15'd0, bus.byte_ready}, 16'h0000);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        while (!bus.byte_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_timeout", {15'd0, bus.byte_ready}, 16'h0001);
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
    endtask

    task automatic send_prog(input int n, input int gap);
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(nn[15:8]);
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; chk("gap_ready", {15'd0, bus.byte_ready}, 16'h0001); end
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(prog[i]);
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; chk("gap_ready", {15'd0, bus.byte_ready}, 16'h0001); end
            send_byte(prog[i][15:8]);
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; chk("gap_ready", {15'd0, bus.byte_ready}, 16'h0001); end
            send_byte(prog[i][7:0]);
        end
    endtask

    // Entered one step after the edge that accepted the final lo byte.
    task automatic run_burst(input int n);
        chk("brst_load", {15'd0, bus.load_instruction}, 16'h0000);
        chk("brst_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
        chk("brst_ready", {15'd0, bus.byte_ready}, 16'h0000);
        chk("brst_busy", {15'd0, bus.busy}, 16'h0001);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("burst_load", {15'd0, bus.load_instruction}, 16'h0001);
            chk("burst_ready", {15'd0, bus.byte_ready}, 16'h0000);
        end
        @(posedge clk); #1;
        chk("restart_load", {15'd0, bus.load_instruction}, 16'h0000);
        chk("restart_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
        chk("restart_done", {15'd0, bus.done}, 16'h0000);
        chk("restart_ready", {15'd0, bus.byte_ready}, 16'h0000);
        @(posedge clk); #1;
        chk("done_pulse", {15'd0, bus.done}, 16'h0001);
        chk("done_pcrun", {15'd0, bus.cpu_pc_reset}, 16'h0000);
        chk("done_busy", {15'd0, bus.busy}, 16'h0000);
        chk("done_ready", {15'd0, bus.byte_ready}, 16'h0001);
        @(posedge clk); #1;
        chk("done_clear", {15'd0, bus.done}, 16'h0000);
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    endtask

    task automatic zero_count(input logic exp_pcrst);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("zero_busy", {15'd0, bus.busy}, 16'h0000);
            chk("zero_pcrst", {15'd0, bus.cpu_pc_reset}, {15'd0, exp_pcrst});
            chk("zero_done", {15'd0, bus.done}, 16'h0000);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        do_reset();

        // Reset values
        chk("rst_ready", {15'd0, bus.byte_ready}, 16'h0001);
        chk("rst_instr", bus.instruction_in, 16'h0000);
        chk("rst_load", {15'd0, bus.load_instruction}, 16'h0000);
        chk("rst_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
        chk("rst_busy", {15'd0, bus.busy}, 16'h0000);
        chk("rst_done", {15'd0, bus.done}, 16'h0000);
        chk("rst_err", {15'd0, bus.load_error}, 16'h0000);

        // Zero-length stream before any load keeps the CPU in reset
        zero_count(1'b1);

        // Continuous 3-word program
        prog[0] = 16'hA123; prog[1] = 16'hB456; prog[2] = 16'hC789;
        send_prog(3, 0);
        run_burst(3);
        chk("imem0", imem[0], 16'hA123);
        chk("imem1", imem[1], 16'hB456);
        chk("imem2", imem[2], 16'hC789);

        // Same program with 5 idle cycles between bytes
        send_prog(3, 5);
        run_burst(3);
        chk("gap_imem2", imem[2], 16'hC789);

        // Zero-length stream after a load lets the CPU keep running
        zero_count(1'b0);

        // 2-word program, CPU runs, then a 1-word reload
        prog[0] = 16'h1234; prog[1] = 16'h5678;
        send_prog(2, 0);
        run_burst(2);
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'h00);
        chk("reload_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
        send_byte(8'h01);
        exp_q.push_back(16'h0FFF);
        send_byte(8'h0F);
        send_byte(8'hFF);
        run_burst(1);
        chk("reload_imem0", imem[0], 16'h0FFF);

        // Maximum length program
        for (int i = 0; i < 16; i++) prog[i] = 16'h1000 + 16'(i) * 16'h0111;
        send_prog(16, 0);
        run_burst(16);
        chk("full_imem0", imem[0], 16'h1000);
        chk("full_imem15", imem[15], 16'h1FFF);

        // Length 17 is out of range: sticky error until reset
        send_byte(8'h00);
        send_byte(8'h11);
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("err_flag", {15'd0, bus.load_error}, 16'h0001);
            chk("err_ready", {15'd0, bus.byte_ready}, 16'h0000);
            chk("err_busy", {15'd0, bus.busy}, 16'h0000);
            chk("err_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        do_reset();
        chk("err_cleared", {15'd0, bus.load_error}, 16'h0000);
        chk("err_rst_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);

        // Reset during the second burst cycle of a 4-word load
        prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;
        send_prog(4, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_load", {15'd0, bus.load_instruction}, 16'h0001);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_load", {15'd0, bus.load_instruction}, 16'h0000);
        chk("mid_rst_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
        chk("mid_rst_busy", {15'd0, bus.busy}, 16'h0000);
        chk("mid_rst_ready", {15'd0, bus.byte_ready}, 16'h0001);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_idle_pcrst", {15'd0, bus.cpu_pc_reset}, 16'h0001);
        prog[0] = 16'h5555; prog[1] = 16'h6666; prog[2] = 16'h7777; prog[3] = 16'h8888;
        send_prog(4, 0);
        run_burst(4);
        chk("after_imem0", imem[0], 16'h5555);
        chk("after_imem3", imem[3], 16'h8888);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
